// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: issues the host start pulse, decodes and checksums the 40-bit
// frame, and publishes the integer humidity/temperature bytes as BCD digits for the display.
module dht11_reader #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned BIT_THRESH_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       busy,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] hum_int,
    output logic [7:0] temp_int,
    output logic [3:0] hum_hundreds,
    output logic [3:0] hum_tens,
    output logic [3:0] hum_units,
    output logic [3:0] temp_hundreds,
    output logic [3:0] temp_tens,
    output logic [3:0] temp_units
);
    localparam int unsigned DIV = CLK_HZ / 1000000;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX   = PW'(DIV - 1);
    localparam logic [15:0]   START_CNT   = 16'(START_LOW_US);
    localparam logic [15:0]   TIMEOUT_CNT = 16'(TIMEOUT_US);
    localparam logic [15:0]   THRESH_CNT  = 16'(BIT_THRESH_US);

    typedef enum logic [3:0] {
        StIdle, StStartLow, StRelease, StRespLow, StRespHigh,
        StBitLow, StBitHigh, StCheck, StBcd, StDone
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   us_cnt_q, us_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [39:0]   frame_q, frame_d;
    logic [2:0]    bcd_cnt_q, bcd_cnt_d;
    logic [19:0]   dd_hum_q, dd_hum_d, dd_temp_q, dd_temp_d;
    logic          dht_oe_q, dht_oe_d, busy_q, busy_d, valid_q, valid_d, err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    hum_int_q, hum_int_d, temp_int_q, temp_int_d;
    logic [11:0]   hum_bcd_q, hum_bcd_d, temp_bcd_q, temp_bcd_d;

    logic        rise, fall, tick;
    logic [7:0]  sum;
    logic [19:0] dd_hum_step, dd_temp_step;

    // One double-dabble iteration: +3 on any BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble(input logic [19:0] x);
        logic [19:0] y;
        y = x;
        for (int i = 0; i < 3; i++) begin
            if (y[8+4*i +: 4] >= 4'd5) begin
                y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
            end
        end
        return {y[18:0], 1'b0};
    endfunction

    assign rise         = sync2_q & ~prev_q;
    assign fall         = ~sync2_q & prev_q;
    assign tick         = (presc_q == PRESC_MAX);
    assign sum          = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign dd_hum_step  = dabble(dd_hum_q);
    assign dd_temp_step = dabble(dd_temp_q);

    always_comb begin
        state_d    = state_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        bcd_cnt_d  = bcd_cnt_q;
        dd_hum_d   = dd_hum_q;
        dd_temp_d  = dd_temp_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        hum_int_d  = hum_int_q;
        temp_int_d = temp_int_q;
        hum_bcd_d  = hum_bcd_q;
        temp_bcd_d = temp_bcd_q;
        us_cnt_d   = us_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StStartLow;
            end
            StStartLow: begin
                if (us_cnt_q >= START_CNT) state_d = StRelease;
            end
            StRelease, StRespLow, StRespHigh: begin
                if (state_q == StRelease && fall) begin
                    state_d = StRespLow;
                end else if (state_q == StRespLow && rise) begin
                    state_d = StRespHigh;
                end else if (state_q == StRespHigh && fall) begin
                    state_d   = StBitLow;
                    bit_cnt_d = '0;
                end else if (us_cnt_q > TIMEOUT_CNT) begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                end
            end
            StBitLow, StBitHigh: begin
                if (state_q == StBitLow && rise) begin
                    state_d = StBitHigh;
                end else if (state_q == StBitHigh && fall) begin
                    frame_d   = {frame_q[38:0], us_cnt_q > THRESH_CNT};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd39) ? StCheck : StBitLow;
                end else if (us_cnt_q > TIMEOUT_CNT) begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                end
            end
            StCheck: begin
                if (sum == frame_q[7:0]) begin
                    state_d   = StBcd;
                    bcd_cnt_d = '0;
                    dd_hum_d  = {12'd0, frame_q[39:32]};
                    dd_temp_d = {12'd0, frame_q[23:16]};
                end else begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                end
            end
            StBcd: begin
                dd_hum_d  = dd_hum_step;
                dd_temp_d = dd_temp_step;
                bcd_cnt_d = bcd_cnt_q + 3'd1;
                // Publish on the DONE entry edge so digits and valid appear together.
                if (bcd_cnt_q == 3'd7) begin
                    state_d    = StDone;
                    hum_int_d  = frame_q[39:32];
                    temp_int_d = frame_q[23:16];
                    hum_bcd_d  = dd_hum_step[19:8];
                    temp_bcd_d = dd_temp_step[19:8];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            us_cnt_d = '0;
        end else if (tick && us_cnt_q != 16'hFFFF) begin
            us_cnt_d = us_cnt_q + 16'd1;
        end

        dht_oe_d = (state_d == StStartLow);
        busy_d   = (state_d != StIdle);
        valid_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            presc_q    <= '0;
            us_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            bcd_cnt_q  <= '0;
            dd_hum_q   <= '0;
            dd_temp_q  <= '0;
            dht_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            hum_int_q  <= '0;
            temp_int_q <= '0;
            hum_bcd_q  <= '0;
            temp_bcd_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= dht_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            presc_q    <= presc_d;
            us_cnt_q   <= us_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            bcd_cnt_q  <= bcd_cnt_d;
            dd_hum_q   <= dd_hum_d;
            dd_temp_q  <= dd_temp_d;
            dht_oe_q   <= dht_oe_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            hum_int_q  <= hum_int_d;
            temp_int_q <= temp_int_d;
            hum_bcd_q  <= hum_bcd_d;
            temp_bcd_q <= temp_bcd_d;
        end
    end

    assign dht_oe        = dht_oe_q;
    assign busy          = busy_q;
    assign valid         = valid_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign hum_int       = hum_int_q;
    assign temp_int      = temp_int_q;
    assign hum_hundreds  = hum_bcd_q[11:8];
    assign hum_tens      = hum_bcd_q[7:4];
    assign hum_units     = hum_bcd_q[3:0];
    assign temp_hundreds = temp_bcd_q[11:8];
    assign temp_tens     = temp_bcd_q[7:4];
    assign temp_units    = temp_bcd_q[3:0];

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a timed DHT11 line model plus a cycle-level reference for
// the published outputs and the valid/err pulses.
module tb_dht11_reader;
    localparam int CLK_HZ   = 2000000;
    localparam int DIV      = CLK_HZ / 1000000;
    localparam int START_US = 100;
    localparam int TOUT_US  = 200;
    localparam int THR_US   = 50;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sens = 1'b1;
    logic       dht_in, dht_oe, busy, valid, err;
    logic [1:0] err_code;
    logic [7:0] hum_int, temp_int;
    logic [3:0] hh, ht, hu, th, tt, tu;

    // Open-drain line with pull-up: host drive wins, otherwise the sensor model.
    assign dht_in = dht_oe ? 1'b0 : sens;

    dht11_reader #(
        .CLK_HZ       (CLK_HZ),
        .START_LOW_US (START_US),
        .TIMEOUT_US   (TOUT_US),
        .BIT_THRESH_US(THR_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dht_in       (dht_in),
        .dht_oe       (dht_oe),
        .busy         (busy),
        .valid        (valid),
        .err          (err),
        .err_code     (err_code),
        .hum_int      (hum_int),
        .temp_int     (temp_int),
        .hum_hundreds (hh),
        .hum_tens     (ht),
        .hum_units    (hu),
        .temp_hundreds(th),
        .temp_tens    (tt),
        .temp_units   (tu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_miss = 0;
    int valid_cnt = 0, err_cnt = 0;
    int exp_valid_cyc = -1, err_lo = 1, err_hi = 0, rst_at = -1;
    logic [1:0]  exp_code = 2'd0, m_code = 2'd0;
    logic [7:0]  p_hum = 8'd0, p_temp = 8'd0, m_hum = 8'd0, m_temp = 8'd0;
    logic [11:0] m_hbcd = 12'd0, m_tbcd = 12'd0;

    function automatic logic [11:0] to_bcd(input logic [7:0] b);
        int v;
        v = int'(b);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic compare_loop();
        logic in_win;
        forever begin
            @(negedge clk);
            if (cyc == rst_at) begin
                m_hum = 0; m_temp = 0; m_hbcd = 0; m_tbcd = 0; m_code = 0;
            end
            if (cyc == exp_valid_cyc) begin
                m_hum  = p_hum;
                m_temp = p_temp;
                m_hbcd = to_bcd(p_hum);
                m_tbcd = to_bcd(p_temp);
            end
            in_win = (cyc >= err_lo) && (cyc <= err_hi);
            if (err && in_win) begin
                m_code = exp_code;
                err_cnt++;
            end
            if (valid) valid_cnt++;
            chk("valid", int'(valid), int'(cyc == exp_valid_cyc));
            chk("err_unexpected", int'(err && !in_win), 0);
            chk("valid_err_overlap", int'(valid && err), 0);
            if (err) chk("busy_at_err", int'(busy), 0);
            if (valid) chk("busy_at_valid", int'(busy), 1);
            chk("err_code", int'(err_code), int'(m_code));
            chk("hum_int", int'(hum_int), int'(m_hum));
            chk("temp_int", int'(temp_int), int'(m_temp));
            chk("hum_digits", int'({hh, ht, hu}), int'(m_hbcd));
            chk("temp_digits", int'({th, tt, tu}), int'(m_tbcd));
        end
    endtask

    // One reading; stall_bit holds the line high mid-bit, rst_bit resets during that bit.
    task automatic run_frame(input logic [39:0] f, input int stall_bit, input int rst_bit);
        int n, c, e0, v0;
        logic [7:0] sum;
        logic good;
        sum  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        good = (sum == f[7:0]);
        e0 = err_cnt;
        v0 = valid_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("dht_oe_asserted", int'(dht_oe), 1);
        n = 0;
        while (dht_oe && n < START_US * DIV + 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_low_len_ok", int'(n >= (START_US - 1) * DIV && n <= START_US * DIV + 2), 1);
        chk("busy_in_release", int'(busy), 1);
        wait_us(20);
        sens = 1'b0; wait_us(80);
        sens = 1'b1; wait_us(80);
        for (int i = 0; i < 40; i++) begin
            sens = 1'b0;
            if (i == 5) begin
                @(negedge clk); start = 1'b1;
                @(negedge clk); start = 1'b0;
                wait_us(49);
            end else begin
                wait_us(50);
            end
            sens = 1'b1;
            if (i == rst_bit) begin
                wait_us(10);
                rst_at = cyc + 1;
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", int'(busy), 0);
                chk("rst_dht_oe", int'(dht_oe), 0);
                chk("rst_hum_int", int'(hum_int), 0);
                chk("rst_temp_digits", int'({th, tt, tu}), 0);
                wait_us(60);
                chk("rst_stays_idle", int'(busy), 0);
                chk("rst_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
                return;
            end
            if (i == stall_bit) begin
                c = cyc;
                exp_code = 2'd2;
                err_lo = c + TOUT_US * DIV;
                err_hi = c + (TOUT_US + 2) * DIV + 4;
                wait_us(300);
                sens = 1'b0; wait_us(50);
                sens = 1'b1; wait_us(20);
                chk("stall_err_count", err_cnt - e0, 1);
                chk("stall_code_lit", int'(err_code), 2);
                chk("stall_idle", int'(busy), 0);
                chk("stall_no_valid", valid_cnt - v0, 0);
                err_lo = 1; err_hi = 0;
                return;
            end
            wait_us(f[39-i] ? 70 : 27);
            sens = 1'b0;
            if (i == 39) begin
                c = cyc;
                if (good) begin
                    p_hum = f[39:32];
                    p_temp = f[23:16];
                    exp_valid_cyc = c + 12;
                end else begin
                    exp_code = 2'd3;
                    err_lo = c + 4;
                    err_hi = c + 4;
                end
            end
        end
        wait_us(50);
        sens = 1'b1;
        wait_us(30);
        chk("frame_valid_count", valid_cnt - v0, good ? 1 : 0);
        chk("frame_err_count", err_cnt - e0, good ? 0 : 1);
        chk("start_not_queued", int'(busy), 0);
        err_lo = 1; err_hi = 0;
    endtask

    task automatic no_response();
        int s, e0;
        e0 = err_cnt;
        @(negedge clk);
        s = cyc;
        exp_code = 2'd1;
        err_lo = s + (START_US + TOUT_US) * DIV - 2 * DIV;
        err_hi = s + (START_US + TOUT_US + 2) * DIV + 4;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc <= err_hi + 2) @(negedge clk);
        chk("noresp_err_count", err_cnt - e0, 1);
        chk("noresp_code_lit", int'(err_code), 1);
        chk("noresp_idle", int'(busy), 0);
        chk("noresp_dht_oe", int'(dht_oe), 0);
        err_lo = 1; err_hi = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r0, r1, r2, r3;
        fork
            compare_loop();
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_dht_oe", int'(dht_oe), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_hum_int", int'(hum_int), 0);
        chk("reset_err_code", int'(err_code), 0);

        run_frame(40'h2D_00_17_00_44, -1, -1);
        chk("good_hum_digits_lit", int'({hh, ht, hu}), 'h045);
        chk("good_temp_digits_lit", int'({th, tt, tu}), 'h023);
        chk("good_hum_int_lit", int'(hum_int), 45);
        chk("good_temp_int_lit", int'(temp_int), 23);

        run_frame(40'h2D_00_17_00_45, -1, -1);
        chk("badsum_code_lit", int'(err_code), 3);
        chk("badsum_hum_hold_lit", int'({hh, ht, hu}), 'h045);
        chk("badsum_temp_hold_lit", int'({th, tt, tu}), 'h023);

        no_response();

        run_frame(40'hFF_00_80_00_7F, -1, -1);
        chk("ext_hum_digits_lit", int'({hh, ht, hu}), 'h255);
        chk("ext_temp_digits_lit", int'({th, tt, tu}), 'h128);
        chk("ext_hum_int_lit", int'(hum_int), 255);

        run_frame(40'h3C_00_1A_00_56, 10, -1);
        chk("stall_hold_lit", int'({hh, ht, hu}), 'h255);

        run_frame(40'h2D_00_17_00_44, -1, 19);

        for (int k = 0; k < 3; k++) begin
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            if (k == 2 && $urandom_range(0, 1) == 1)
                run_frame({r0, r1, r2, r3, 8'(r0 + r1 + r2 + r3 + 8'd1)}, -1, -1);
            else
                run_frame({r0, r1, r2, r3, 8'(r0 + r1 + r2 + r3)}, -1, -1);
        end

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
